// File: rtl/softmax_max_buffer_pkg.sv
// Shared types and default sizing for the softmax input/max stage.
package softmax_max_buffer_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_VEC_LEN = 8;
  localparam int DEF_IDX_W   = 3;

  typedef enum logic {
    ST_LOAD   = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  typedef logic signed [DEF_DATA_W-1:0] logit_t;

endpackage

// File: rtl/softmax_max_buffer_idx_counter.sv
// Inc-gated index counter that wraps from CNT_MAX-1 back to zero.
module softmax_max_buffer_idx_counter #(
  parameter int WIDTH   = 3,
  parameter int CNT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  assign wrap = (cnt == WIDTH'(CNT_MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/softmax_max_buffer.sv
// Captures one logit vector while tracking its maximum, then replays each
// element with the maximum and the (x - max) difference for the exp stage.
module softmax_max_buffer
  import softmax_max_buffer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W:0]   out_diff,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last
);

  state_t                    state;
  logic signed [DATA_W-1:0]  max_reg;
  logic [DATA_W-1:0]         mem [VEC_LEN];
  logic [IDX_W-1:0]          wr_idx;
  logic [IDX_W-1:0]          rd_idx;
  logic                      wr_wrap;
  logic                      rd_wrap;
  logic                      accept;
  logic                      xfer;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  softmax_max_buffer_idx_counter #(
    .WIDTH   (IDX_W),
    .CNT_MAX (VEC_LEN)
  ) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .cnt   (wr_idx),
    .wrap  (wr_wrap)
  );

  softmax_max_buffer_idx_counter #(
    .WIDTH   (IDX_W),
    .CNT_MAX (VEC_LEN)
  ) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (xfer),
    .cnt   (rd_idx),
    .wrap  (rd_wrap)
  );

  // Element storage carries no reset; contents are always rewritten before replay.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      max_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (wr_idx == '0 || $signed(in_data) > max_reg) begin
              max_reg <= $signed(in_data);
            end
            if (wr_wrap) begin
              state     <= ST_REPLAY;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_REPLAY: begin
          if (xfer && rd_wrap) begin
            state     <= ST_LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = mem[rd_idx];
  assign out_max  = max_reg;
  assign out_idx  = rd_idx;
  assign out_last = rd_wrap;
  // Sign-extend both operands so the full range fits without saturation.
  assign out_diff = {out_data[DATA_W-1], out_data} - {max_reg[DATA_W-1], max_reg};

endmodule

// File: tb/tb_softmax_max_buffer.sv
// Randomised self-checking bench for softmax_max_buffer against a vector-level model.
module tb_softmax_max_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_max;
  logic [16:0] out_diff;
  logic [2:0]  out_idx;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [52:0] got_pk [8];
  int          got_n;
  int          stall_viol;
  int          inrdy_hi;

  softmax_max_buffer #(
    .DATA_W  (16),
    .VEC_LEN (8),
    .IDX_W   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_max   (out_max),
    .out_diff  (out_diff),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic int vec_max(input int v[8]);
    int m = v[0];
    for (int i = 1; i < 8; i++) if (v[i] > m) m = v[i];
    return m;
  endfunction

  // Expected replay element: {data, max, diff, idx, last}
  function automatic logic [52:0] exp_elem(input int v[8], input int i);
    int m = vec_max(v);
    return {16'(v[i]), 16'(m), 17'(v[i] - m), 3'(i), 1'(i == 7)};
  endfunction

  // mode 0: continuous, 1: pattern 1,0,1,1,0 repeated, 2: random valid
  task automatic load_vec(input int v[8], input int mode, output int cyc, output int early);
    int  k;
    bit  vld;
    bit  acc;
    k = 0; cyc = 0; early = 0;
    while (k < 8 && cyc < 200) begin
      case (mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 5 == 0) || (cyc % 5 == 2) || (cyc % 5 == 3);
        default: vld = 1'($urandom_range(0, 1));
      endcase
      in_valid = vld;
      in_data  = vld ? 16'(v[k]) : 16'h7ABC;
      if (out_valid) early++;
      acc = vld && in_ready;
      @(posedge clk);
      if (acc) k++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (k != 8) cyc = -1;
  endtask

  // mode 0: ready always, 1: pattern 1,0,0,1 repeated, 2: random ready
  task automatic collect(input int mode, input bit hold_in, input int hold_val, output int cyc);
    logic [52:0] cur;
    logic [52:0] held;
    bit          rdy;
    bit          prev_stall;
    got_n = 0; stall_viol = 0; inrdy_hi = 0; cyc = 0; prev_stall = 0; held = '0;
    while (got_n < 8 && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      in_valid  = hold_in;
      in_data   = 16'(hold_val);
      cur = {out_data, out_max, out_diff, out_idx, out_last};
      if (prev_stall && cur !== held) stall_viol++;
      if (out_valid && in_ready) inrdy_hi++;
      if (out_valid && rdy) begin
        got_pk[got_n] = cur;
        got_n++;
      end
      prev_stall = out_valid && !rdy;
      held = cur;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_max !== 16'd0 ||
        out_idx !== 3'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b vld=%b max=%h idx=%0d last=%b, want rdy=1 vld=0 max=0 idx=0 last=0",
               in_ready, out_valid, out_max, out_idx, out_last);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int v[8];
    int lc, cc, early;
    v = '{3, -5, 7, 7, 0, -128, 12, 1};
    load_vec(v, 0, lc, early);
    n_checks++;
    if (lc !== 8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency: got cycles=%0d vld=%b rdy=%b, want 8 1 0", lc, out_valid, in_ready);
    end
    collect(0, 1'b0, 0, cc);
    n_checks++;
    if (got_n !== 8 || cc !== 8) begin
      n_fail++;
      $display("FAIL basic_count: got %0d transfers in %0d cycles, want 8 in 8", got_n, cc);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_pk[i] !== exp_elem(v, i)) begin
        n_fail++;
        $display("FAIL basic[%0d]: got %h want %h", i, got_pk[i], exp_elem(v, i));
      end
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_return: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_all_negative();
    int v[8];
    int lc, cc, early;
    v = '{-3, -1, -7, -2, -9, -4, -8, -6};
    load_vec(v, 0, lc, early);
    collect(0, 1'b0, 0, cc);
    n_checks++;
    if (got_n !== 8) begin
      n_fail++;
      $display("FAIL neg_count: got %0d want 8", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_pk[i] !== exp_elem(v, i)) begin
        n_fail++;
        $display("FAIL neg[%0d]: got %h want %h", i, got_pk[i], exp_elem(v, i));
      end
    end
  endtask

  task automatic test_backpressure();
    int v[8];
    int lc, cc, early;
    for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
    load_vec(v, 0, lc, early);
    collect(1, 1'b0, 0, cc);
    n_checks++;
    if (got_n !== 8 || cc !== 16 || stall_viol !== 0 || inrdy_hi !== 0) begin
      n_fail++;
      $display("FAIL bp_flow: got xfers=%0d cycles=%0d unstable=%0d in_ready_hi=%0d, want 8 16 0 0",
               got_n, cc, stall_viol, inrdy_hi);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_pk[i] !== exp_elem(v, i)) begin
        n_fail++;
        $display("FAIL bp[%0d]: got %h want %h", i, got_pk[i], exp_elem(v, i));
      end
    end
  endtask

  task automatic test_gaps();
    int v[8];
    int lc, cc, early;
    v = '{-20, 44, -300, 44, 1000, -1000, 999, 5};
    load_vec(v, 1, lc, early);
    n_checks++;
    if (lc !== 13 || early !== 0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_load: got cycles=%0d early_valid=%0d vld=%b, want 13 0 1", lc, early, out_valid);
    end
    collect(0, 1'b0, 0, cc);
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_pk[i] !== exp_elem(v, i)) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got %h want %h", i, got_pk[i], exp_elem(v, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int v[8];
    int lc, cc, early;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(100 * (i + 1));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_max !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_load: got rdy=%b vld=%b max=%h, want 1 0 0", in_ready, out_valid, out_max);
    end
    rst_n = 1'b1;
    v = '{4, 4, 4, 4, 4, 4, 4, 4};
    load_vec(v, 0, lc, early);
    collect(0, 1'b0, 0, cc);
    n_checks++;
    if (got_n !== 8) begin
      n_fail++;
      $display("FAIL rst_fours_count: got %0d want 8", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_pk[i] !== exp_elem(v, i)) begin
        n_fail++;
        $display("FAIL rst_fours[%0d]: got %h want %h", i, got_pk[i], exp_elem(v, i));
      end
    end
    // Reset in the middle of a replay.
    for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(0, 2000)) - 1000;
    load_vec(v, 0, lc, early);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_replay: got vld=%b rdy=%b idx=%0d, want 0 1 0", out_valid, in_ready, out_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int a[8];
    int b[8];
    int lc, cc, early;
    for (int i = 0; i < 8; i++) begin
      a[i] = int'($urandom_range(0, 65535)) - 32768;
      b[i] = int'($urandom_range(0, 200)) - 100;
    end
    load_vec(a, 0, lc, early);
    collect(0, 1'b1, b[0], cc);
    n_checks++;
    if (inrdy_hi !== 0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handoff: got in_ready_hi=%0d rdy=%b vld=%b, want 0 1 0", inrdy_hi, in_ready, out_valid);
    end
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_pk[i] !== exp_elem(a, i)) begin
        n_fail++;
        $display("FAIL b2b_a[%0d]: got %h want %h", i, got_pk[i], exp_elem(a, i));
      end
    end
    load_vec(b, 0, lc, early);
    n_checks++;
    if (lc !== 8) begin
      n_fail++;
      $display("FAIL b2b_load: got %0d cycles want 8", lc);
    end
    collect(0, 1'b0, 0, cc);
    for (int i = 0; i < got_n; i++) begin
      n_checks++;
      if (got_pk[i] !== exp_elem(b, i)) begin
        n_fail++;
        $display("FAIL b2b_b[%0d]: got %h want %h", i, got_pk[i], exp_elem(b, i));
      end
    end
  endtask

  task automatic test_random();
    int v[8];
    int lc, cc, early;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(0, 65535)) - 32768;
      if (n == 0) begin
        v[2] = -32768;
        v[6] = 32767;
      end
      load_vec(v, 2, lc, early);
      collect(2, 1'b0, 0, cc);
      n_checks++;
      if (got_n !== 8 || stall_viol !== 0 || early !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_flow: got xfers=%0d unstable=%0d early=%0d, want 8 0 0",
                 n, got_n, stall_viol, early);
      end
      for (int i = 0; i < got_n; i++) begin
        n_checks++;
        if (got_pk[i] !== exp_elem(v, i)) begin
          n_fail++;
          $display("FAIL rand%0d[%0d]: got %h want %h", n, i, got_pk[i], exp_elem(v, i));
        end
      end
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_all_negative();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
